// File: rtl/commit_checker_if.sv
// Retire-stream bus between the core's commit stage and commit_checker.
// The master drives commits; the slave (checker) reports faults.
`default_nettype none

interface commit_checker_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic             check_en;
  logic             commit_valid;
  logic [XLEN-1:0]  commit_pc;
  logic [XLEN-1:0]  commit_next_pc;
  logic             fault_valid;
  logic [2:0]       fault_code;
  logic [XLEN-1:0]  fault_pc;
  logic             halted;
  logic [CNT_W-1:0] commit_count;

  modport master (
    output check_en, commit_valid, commit_pc, commit_next_pc,
    input  fault_valid, fault_code, fault_pc, halted, commit_count
  );

  modport slave (
    input  check_en, commit_valid, commit_pc, commit_next_pc,
    output fault_valid, fault_code, fault_pc, halted, commit_count
  );
endinterface

`default_nettype wire

// File: rtl/commit_checker.sv
// +-----------------------------------------------------------------------+
// | commit_checker: retire-stream monitor (PC alignment, continuity,      |
// | watchdog) with a registered fault pulse and sticky halt.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module commit_checker #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              TIMEOUT  = 1024,
  parameter int              CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  commit_checker_if.slave  bus
);

  localparam int              IDLE_W    = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_PC_ALIGN  = 3'd1;
  localparam logic [2:0] CODE_PC_DISC   = 3'd2;
  localparam logic [2:0] CODE_NPC_ALIGN = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t            state_q,       state_d;
  logic [XLEN-1:0]   expected_pc_q, expected_pc_d;
  logic [IDLE_W-1:0] idle_cnt_q,    idle_cnt_d;
  logic [CNT_W-1:0]  commit_count_q, commit_count_d;
  logic              fault_valid_q, fault_valid_d;
  logic [2:0]        fault_code_q,  fault_code_d;
  logic [XLEN-1:0]   fault_pc_q,    fault_pc_d;
  logic              halted_q,      halted_d;

  logic              fault_hit;
  logic [2:0]        fault_code_new;
  logic [XLEN-1:0]   fault_pc_new;

  always_comb begin
    state_d        = state_q;
    expected_pc_d  = expected_pc_q;
    idle_cnt_d     = idle_cnt_q;
    commit_count_d = commit_count_q;
    fault_valid_d  = 1'b0;
    fault_code_d   = fault_code_q;
    fault_pc_d     = fault_pc_q;
    halted_d       = halted_q;
    fault_hit      = 1'b0;
    fault_code_new = CODE_NONE;
    fault_pc_new   = bus.commit_pc;

    if (state_q == RUN) begin
      if (bus.commit_valid) begin
        commit_count_d = commit_count_q + CNT_W'(1);
        expected_pc_d  = bus.commit_next_pc;
        idle_cnt_d     = '0;
        if (bus.check_en) begin
          // Priority: own-PC alignment, then continuity, then next-PC alignment.
          if (bus.commit_pc[1:0] != 2'b00) begin
            fault_hit      = 1'b1;
            fault_code_new = CODE_PC_ALIGN;
          end else if (bus.commit_pc != expected_pc_q) begin
            fault_hit      = 1'b1;
            fault_code_new = CODE_PC_DISC;
          end else if (bus.commit_next_pc[1:0] != 2'b00) begin
            fault_hit      = 1'b1;
            fault_code_new = CODE_NPC_ALIGN;
          end
        end
      end else if (bus.check_en) begin
        if (idle_cnt_q == IDLE_LAST) begin
          fault_hit      = 1'b1;
          fault_code_new = CODE_TIMEOUT;
          fault_pc_new   = expected_pc_q;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end else begin
        idle_cnt_d = '0;
      end

      if (fault_hit) begin
        state_d       = FAULT;
        fault_valid_d = 1'b1;
        fault_code_d  = fault_code_new;
        fault_pc_d    = fault_pc_new;
        halted_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      expected_pc_q  <= RESET_PC;
      idle_cnt_q     <= '0;
      commit_count_q <= '0;
      fault_valid_q  <= 1'b0;
      fault_code_q   <= CODE_NONE;
      fault_pc_q     <= '0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_pc_q  <= expected_pc_d;
      idle_cnt_q     <= idle_cnt_d;
      commit_count_q <= commit_count_d;
      fault_valid_q  <= fault_valid_d;
      fault_code_q   <= fault_code_d;
      fault_pc_q     <= fault_pc_d;
      halted_q       <= halted_d;
    end
  end

  assign bus.fault_valid  = fault_valid_q;
  assign bus.fault_code   = fault_code_q;
  assign bus.fault_pc     = fault_pc_q;
  assign bus.halted       = halted_q;
  assign bus.commit_count = commit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_checker.sv
// Self-checking bench for commit_checker: vector table plus watchdog/reset sequences.
`default_nettype none

module tb_commit_checker;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  commit_checker_if #(.XLEN(64), .CNT_W(64)) bus ();

  commit_checker #(
    .XLEN(64), .RESET_PC(RPC), .TIMEOUT(8), .CNT_W(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        fv;
    logic [2:0]  code;
    logic [63:0] fpc;
    logic        halt;
    logic [63:0] cnt;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        cv;
    logic [63:0] pc;
    logic [63:0] npc;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(logic fv, logic [2:0] code, logic [63:0] fpc,
                              logic halt, logic [63:0] cnt);
    exp_t e;
    e.fv = fv; e.code = code; e.fpc = fpc; e.halt = halt; e.cnt = cnt;
    return e;
  endfunction

  function automatic void add(logic rst, logic ce, logic cv, logic [63:0] pc,
                              logic [63:0] npc, exp_t e);
    vec_t v;
    v.rst = rst; v.ce = ce; v.cv = cv; v.pc = pc; v.npc = npc; v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic compare(string name, exp_t e);
    n_checks++;
    if (bus.fault_valid === e.fv && bus.fault_code === e.code &&
        bus.fault_pc === e.fpc && bus.halted === e.halt &&
        bus.commit_count === e.cnt)
      n_pass++;
    else
      $display("FAIL %s: got fv=%0b code=%0d pc=%h halt=%0b cnt=%0d, want fv=%0b code=%0d pc=%h halt=%0b cnt=%0d",
               name, bus.fault_valid, bus.fault_code, bus.fault_pc, bus.halted,
               bus.commit_count, e.fv, e.code, e.fpc, e.halt, e.cnt);
  endtask

  task automatic step(string name, logic ce, logic cv, logic [63:0] pc,
                      logic [63:0] npc, exp_t e);
    bus.check_en       = ce;
    bus.commit_valid   = cv;
    bus.commit_pc      = pc;
    bus.commit_next_pc = npc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      compare(name, sb.pop_front());
    end
  endtask

  // Reset is asserted off-edge and checked before any clock edge occurs.
  task automatic apply_reset();
    bus.check_en       = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_pc      = '0;
    bus.commit_next_pc = '0;
    #2 rst_n = 1'b0;
    #1;
    compare("async reset", mk(1'b0, 3'd0, 64'd0, 1'b0, 64'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  exp_t idle1;

  initial begin
    // rst, ce, cv, pc, next_pc, {fv, code, fault_pc, halted, count}
    add(1, 1, 1, RPC,        RPC + 4,      mk(0, 0, 0, 0, 1));
    add(0, 1, 1, RPC + 4,    RPC + 'h10,   mk(0, 0, 0, 0, 2));
    add(0, 1, 1, RPC + 'h10, RPC + 'h14,   mk(0, 0, 0, 0, 3));
    add(0, 1, 0, 0,          0,            mk(0, 0, 0, 0, 3));
    add(0, 1, 1, RPC + 'h18, RPC + 'h1c,   mk(1, 2, RPC + 'h18, 1, 4));
    add(0, 1, 1, RPC + 'h14, RPC + 'h18,   mk(0, 2, RPC + 'h18, 1, 4));
    add(0, 1, 0, 0,          0,            mk(0, 2, RPC + 'h18, 1, 4));
    add(1, 1, 1, RPC,        RPC + 4,      mk(0, 0, 0, 0, 1));
    add(0, 1, 1, RPC + 8,    RPC + 'hc,    mk(1, 2, RPC + 8, 1, 2));
    add(0, 1, 1, RPC + 4,    RPC + 8,      mk(0, 2, RPC + 8, 1, 2));
    add(1, 1, 1, RPC,        RPC + 4,      mk(0, 0, 0, 0, 1));
    add(0, 1, 1, RPC + 2,    RPC + 6,      mk(1, 1, RPC + 2, 1, 2));
    add(1, 1, 1, RPC + 8,    RPC + 6,      mk(1, 2, RPC + 8, 1, 1));
    add(1, 1, 1, RPC,        RPC + 'h41,   mk(1, 3, RPC, 1, 1));
    add(0, 1, 0, 0,          0,            mk(0, 3, RPC, 1, 1));
    add(1, 0, 1, 64'h1234,   64'h5677,     mk(0, 0, 0, 0, 1));
    add(0, 0, 1, 64'h3,      64'h1,        mk(0, 0, 0, 0, 2));
    add(0, 1, 1, 64'h1,      64'h8,        mk(1, 1, 64'h1, 1, 3));

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      step($sformatf("vec%0d", i), vecs[i].ce, vecs[i].cv, vecs[i].pc,
           vecs[i].npc, vecs[i].e);
    end

    // Watchdog fires on the 8th idle edge and pulses for one cycle.
    apply_reset();
    step("wd1 commit", 1, 1, RPC, RPC + 'h100, mk(0, 0, 0, 0, 1));
    idle1 = mk(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step("wd1 idle", 1, 0, 0, 0, idle1);
    step("wd1 timeout", 1, 0, 0, 0, mk(1, 4, RPC + 'h100, 1, 1));
    step("wd1 frozen", 1, 1, RPC + 'h100, RPC + 'h104, mk(0, 4, RPC + 'h100, 1, 1));

    // Commit on idle cycle 7 restarts the count.
    apply_reset();
    step("wd2 commit", 1, 1, RPC, RPC + 'h100, mk(0, 0, 0, 0, 1));
    for (int i = 0; i < 6; i++) step("wd2 idle", 1, 0, 0, 0, idle1);
    step("wd2 commit7", 1, 1, RPC + 'h100, RPC + 'h104, mk(0, 0, 0, 0, 2));
    for (int i = 0; i < 7; i++) step("wd2 idle b", 1, 0, 0, 0, mk(0, 0, 0, 0, 2));
    step("wd2 timeout", 1, 0, 0, 0, mk(1, 4, RPC + 'h104, 1, 2));

    // A commit on the would-be timeout cycle wins; check_en low clears the counter.
    apply_reset();
    step("wd3 commit", 1, 1, RPC, RPC + 'h100, mk(0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) step("wd3 idle", 1, 0, 0, 0, idle1);
    step("wd3 commit8", 1, 1, RPC + 'h100, RPC + 'h200, mk(0, 0, 0, 0, 2));
    for (int i = 0; i < 5; i++) step("wd3 idle b", 1, 0, 0, 0, mk(0, 0, 0, 0, 2));
    step("wd3 en low", 0, 0, 0, 0, mk(0, 0, 0, 0, 2));
    for (int i = 0; i < 7; i++) step("wd3 idle c", 1, 0, 0, 0, mk(0, 0, 0, 0, 2));
    step("wd3 timeout", 1, 0, 0, 0, mk(1, 4, RPC + 'h200, 1, 2));

    // Checks disabled: discontinuity and long idle go unreported.
    apply_reset();
    step("dis commit", 0, 1, 64'h10, 64'h20, mk(0, 0, 0, 0, 1));
    for (int i = 0; i < 20; i++) step("dis idle", 0, 0, 0, 0, mk(0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) step("dis en idle", 1, 0, 0, 0, mk(0, 0, 0, 0, 1));
    step("dis en timeout", 1, 0, 0, 0, mk(1, 4, 64'h20, 1, 1));

    // Reset while halted; first commit is checked against RESET_PC again.
    apply_reset();
    step("post reset ok", 1, 1, RPC, RPC + 4, mk(0, 0, 0, 0, 1));
    apply_reset();
    step("post reset bad", 1, 1, RPC + 'h20, RPC + 'h24, mk(1, 2, RPC + 'h20, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
